// File: rtl/vta_gemm_pkg.sv
// ---------------------------------------------------------------------------
// vta_gemm_pkg
// Shared definitions for the VTA GEMM instruction controller:
//   - bit positions and widths of the GEMM instruction fields
//   - opcode constants
//   - FSM state encoding
// ---------------------------------------------------------------------------
package vta_gemm_pkg;

    // Instruction field positions (LSB and width of each field)
    localparam int OPCODE_LSB    = 0;
    localparam int OPCODE_W      = 3;
    localparam int POP_PREV_BIT  = 3;
    localparam int POP_NEXT_BIT  = 4;
    localparam int PUSH_PREV_BIT = 5;
    localparam int PUSH_NEXT_BIT = 6;
    localparam int RESET_BIT     = 7;
    localparam int UOP_BGN_LSB   = 8;
    localparam int UOP_BGN_W     = 13;
    localparam int UOP_END_LSB   = 21;
    localparam int UOP_END_W     = 14;
    localparam int ITER_OUT_LSB  = 35;
    localparam int ITER_OUT_W    = 14;
    localparam int ITER_IN_LSB   = 49;
    localparam int ITER_IN_W     = 14;

    // Opcodes
    localparam logic [2:0] OP_LOAD   = 3'b000;
    localparam logic [2:0] OP_STORE  = 3'b001;
    localparam logic [2:0] OP_GEMM   = 3'b010;
    localparam logic [2:0] OP_FINISH = 3'b011;
    localparam logic [2:0] OP_ALU    = 3'b100;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_DEP = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/dep_tok_cnt.sv
// ---------------------------------------------------------------------------
// dep_tok_cnt
// Saturating up/down dependency-token counter.
// Ports:
//   clk     : clock
//   rst     : asynchronous active-low reset
//   pulse   : token arrival (increment)
//   consume : token consumption (decrement)
//   count   : current number of available tokens
// A pulse at saturation is dropped; pulse together with consume is a no-op.
// ---------------------------------------------------------------------------
module dep_tok_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse,
    input  logic             consume,
    output logic [WIDTH-1:0] count
);

    // Consume at zero is ignored so the counter can never wrap downwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (pulse && !consume && (count != '1)) begin
            count <= count + WIDTH'(1);
        end else if (consume && !pulse && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/gemm_insn_ctrl.sv
// ---------------------------------------------------------------------------
// gemm_insn_ctrl
// Instruction controller for the VTA GEMM core. Accepts one instruction,
// waits for its dependency tokens, replays it to the pipeline once per
// (uop, iter_in, iter_out) point, drains the pipeline and signals done.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   insn_valid/ready   : instruction handshake (ready only in IDLE)
//   insn_data          : incoming GEMM instruction
//   insn_out           : instruction to the pipeline (zero when not issuing)
//   l2g_tok, s2g_tok   : incoming dependency-token pulses
//   g2l_tok, g2s_tok   : outgoing token pulses, asserted with done
//   busy, done         : activity flag and completion pulse
//   perf_cycles/insns  : performance counters
// Optional feature macro: GEMM_CTRL_PERF_EN enables the performance
// counters; without it both counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module gemm_insn_ctrl
    import vta_gemm_pkg::*;
#(
    parameter int INS_WIDTH  = 128,
    parameter int PIPE_DEPTH = 5,
    parameter int TOK_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 insn_valid,
    output logic                 insn_ready,
    input  logic [INS_WIDTH-1:0] insn_data,
    output logic [INS_WIDTH-1:0] insn_out,
    input  logic                 l2g_tok,
    input  logic                 s2g_tok,
    output logic                 g2l_tok,
    output logic                 g2s_tok,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_insns
);

    localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    state_t                 state;
    state_t                 state_next;
    logic [INS_WIDTH-1:0]   insn_q;
    logic                   ready_en;
    logic [UOP_END_W-1:0]   uop_cnt;
    logic [ITER_IN_W-1:0]   in_cnt;
    logic [ITER_OUT_W-1:0]  out_cnt;
    logic [DW-1:0]          drain_cnt;
    logic [TOK_WIDTH-1:0]   l2g_cnt;
    logic [TOK_WIDTH-1:0]   s2g_cnt;

    logic [OPCODE_W-1:0]    opcode;
    logic                   pop_prev, pop_next, push_prev, push_next;
    logic [UOP_END_W-1:0]   uop_bgn;
    logic [UOP_END_W-1:0]   uop_end;
    logic [ITER_OUT_W-1:0]  iter_out;
    logic [ITER_IN_W-1:0]   iter_in;

    logic transfer, dep_ok, has_work;
    logic uop_last, in_last, out_last, issue_last, drain_last;
    logic consume_l2g, consume_s2g;

    // Field decode of the latched instruction; uop_bgn is widened so it can
    // be compared with uop_end and loaded into the uop counter directly.
    assign opcode    = insn_q[OPCODE_LSB +: OPCODE_W];
    assign pop_prev  = insn_q[POP_PREV_BIT];
    assign pop_next  = insn_q[POP_NEXT_BIT];
    assign push_prev = insn_q[PUSH_PREV_BIT];
    assign push_next = insn_q[PUSH_NEXT_BIT];
    assign uop_bgn   = {1'b0, insn_q[UOP_BGN_LSB +: UOP_BGN_W]};
    assign uop_end   = insn_q[UOP_END_LSB +: UOP_END_W];
    assign iter_out  = insn_q[ITER_OUT_LSB +: ITER_OUT_W];
    assign iter_in   = insn_q[ITER_IN_LSB +: ITER_IN_W];

    assign transfer = insn_valid && insn_ready;
    assign dep_ok   = (!pop_prev || (l2g_cnt != '0)) && (!pop_next || (s2g_cnt != '0));

    // Extent is nonzero exactly when every factor is nonzero; an inverted
    // uop range counts as empty.
    assign has_work = (opcode == OP_GEMM) && (uop_end > uop_bgn) &&
                      (iter_in != '0) && (iter_out != '0);

    assign uop_last   = (uop_cnt + UOP_END_W'(1)) == uop_end;
    assign in_last    = (in_cnt + ITER_IN_W'(1)) == iter_in;
    assign out_last   = (out_cnt + ITER_OUT_W'(1)) == iter_out;
    assign issue_last = uop_last && in_last && out_last;
    assign drain_last = drain_cnt == DW'(PIPE_DEPTH - 1);

    // Tokens are taken in the same cycle WAIT_DEP is left.
    assign consume_l2g = (state == ST_WAIT_DEP) && dep_ok && pop_prev;
    assign consume_s2g = (state == ST_WAIT_DEP) && dep_ok && pop_next;

    dep_tok_cnt #(.WIDTH(TOK_WIDTH)) u_l2g (
        .clk     (clk),
        .rst     (rst),
        .pulse   (l2g_tok),
        .consume (consume_l2g),
        .count   (l2g_cnt)
    );

    dep_tok_cnt #(.WIDTH(TOK_WIDTH)) u_s2g (
        .clk     (clk),
        .rst     (rst),
        .pulse   (s2g_tok),
        .consume (consume_s2g),
        .count   (s2g_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (transfer) state_next = ST_WAIT_DEP;
            ST_WAIT_DEP: if (dep_ok) state_next = has_work ? ST_ISSUE : ST_DONE;
            ST_ISSUE:    if (issue_last) state_next = (PIPE_DEPTH == 0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN:    if (drain_last) state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Outputs; ready_en keeps insn_ready low until the first edge after reset.
    always_comb begin
        insn_ready = (state == ST_IDLE) && ready_en;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        g2l_tok    = (state == ST_DONE) && push_prev;
        g2s_tok    = (state == ST_DONE) && push_next;
        insn_out   = (state == ST_ISSUE) ? insn_q : '0;
    end

    // Instruction latch and nested loop counters (uop innermost, then
    // iter_in, then iter_out). The loop counters are armed in WAIT_DEP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en  <= 1'b0;
            insn_q    <= '0;
            uop_cnt   <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            if (transfer) begin
                insn_q <= insn_data;
            end
            if (state == ST_WAIT_DEP) begin
                uop_cnt <= uop_bgn;
                in_cnt  <= '0;
                out_cnt <= '0;
            end else if (state == ST_ISSUE) begin
                if (uop_last) begin
                    uop_cnt <= uop_bgn;
                    if (in_last) begin
                        in_cnt  <= '0;
                        out_cnt <= out_cnt + ITER_OUT_W'(1);
                    end else begin
                        in_cnt <= in_cnt + ITER_IN_W'(1);
                    end
                end else begin
                    uop_cnt <= uop_cnt + UOP_END_W'(1);
                end
            end
            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + DW'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

`ifdef GEMM_CTRL_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_insns_q;

    // Free-running wrap-around counters of busy cycles and completions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles_q <= '0;
            perf_insns_q  <= '0;
        end else begin
            if (busy) perf_cycles_q <= perf_cycles_q + 32'd1;
            if (done) perf_insns_q  <= perf_insns_q + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_insns  = perf_insns_q;
`else
    assign perf_cycles = '0;
    assign perf_insns  = '0;
`endif

endmodule

// File: tb/tb_gemm_insn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gemm_insn_ctrl
// Randomized self-checking bench for gemm_insn_ctrl. Expected behaviour of
// each instruction (issue count, latency, tokens) is computed from the
// instruction fields with plain arithmetic; token counts are tracked as
// saturating integers.
// ---------------------------------------------------------------------------
module tb_gemm_insn_ctrl;

    localparam int INS_WIDTH  = 128;
    localparam int PIPE_DEPTH = 5;
    localparam int TOK_WIDTH  = 4;
    localparam int TOK_MAX    = (1 << TOK_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 insn_valid = 1'b0;
    logic                 insn_ready;
    logic [INS_WIDTH-1:0] insn_data = '0;
    logic [INS_WIDTH-1:0] insn_out;
    logic                 l2g_tok = 1'b0;
    logic                 s2g_tok = 1'b0;
    logic                 g2l_tok;
    logic                 g2s_tok;
    logic                 busy;
    logic                 done;
    logic [31:0]          perf_cycles;
    logic [31:0]          perf_insns;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int l2g_m = 0;
    int s2g_m = 0;
    int done_m = 0;
    int busy_m = 0;

    gemm_insn_ctrl #(
        .INS_WIDTH  (INS_WIDTH),
        .PIPE_DEPTH (PIPE_DEPTH),
        .TOK_WIDTH  (TOK_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .insn_valid  (insn_valid),
        .insn_ready  (insn_ready),
        .insn_data   (insn_data),
        .insn_out    (insn_out),
        .l2g_tok     (l2g_tok),
        .s2g_tok     (s2g_tok),
        .g2l_tok     (g2l_tok),
        .g2s_tok     (g2s_tok),
        .busy        (busy),
        .done        (done),
        .perf_cycles (perf_cycles),
        .perf_insns  (perf_insns)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mkInsn(input logic [2:0] opc, input logic pp, input logic pn,
                                            input logic psp, input logic psn, input int ub,
                                            input int ue, input int io, input int ii);
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[2:0]   = opc;
        w[3]     = pp;
        w[4]     = pn;
        w[5]     = psp;
        w[6]     = psn;
        w[20:8]  = 13'(ub);
        w[34:21] = 14'(ue);
        w[48:35] = 14'(io);
        w[62:49] = 14'(ii);
        return w;
    endfunction

    function automatic int extentOf(input logic [127:0] w);
        int ub, ue, io, ii;
        ub = int'(w[20:8]);
        ue = int'(w[34:21]);
        io = int'(w[48:35]);
        ii = int'(w[62:49]);
        if (w[2:0] != 3'b010 || ue <= ub) return 0;
        return (ue - ub) * io * ii;
    endfunction

    function automatic int satInc(input int c);
        return (c < TOK_MAX) ? c + 1 : c;
    endfunction

    // One idle-time token pulse on the selected inputs (called at a negedge).
    task automatic pulseTok(input bit l, input bit s);
        l2g_tok = l;
        s2g_tok = s;
        @(negedge clk);
        l2g_tok = 1'b0;
        s2g_tok = 1'b0;
        if (l) l2g_m = satInc(l2g_m);
        if (s) s2g_m = satInc(s2g_m);
    endtask

    // Send one instruction and follow it to completion. tok_at>0 drives an
    // l2g pulse in that cycle after acceptance (cycle 1 = first busy cycle).
    task automatic applyStimulus(input logic [127:0] w, input int tok_at);
        int ext, lcyc, dexp, cyc, issued, bad_data, first_issue, last_issue, done_cyc;
        bit pulsed, got_g2l, got_g2s;
        ext = extentOf(w);
        lcyc = (w[3] && l2g_m == 0) ? tok_at + 1 : 1;
        dexp = (ext > 0) ? lcyc + ext + PIPE_DEPTH + 1 : lcyc + 1;
        issued = 0; bad_data = 0; first_issue = 0; last_issue = 0; done_cyc = 0;
        pulsed = 0; got_g2l = 0; got_g2s = 0;

        for (int k = 0; k < 20 && !insn_ready; k++) @(negedge clk);
        checkOutput("ready_before_send", insn_ready, 1'b1);
        insn_data  = w;
        insn_valid = 1'b1;
        @(negedge clk);
        insn_valid = 1'b0;
        insn_data  = {$urandom, $urandom, $urandom, $urandom};
        checkOutput("ready_low_when_busy", insn_ready, 1'b0);

        for (cyc = 1; cyc <= dexp + 30; cyc++) begin
            if (insn_out != '0) begin
                issued++;
                if (first_issue == 0) first_issue = cyc;
                last_issue = cyc;
                if (insn_out !== w) bad_data++;
            end
            if (!busy) bad_data++;
            if (done) begin
                done_cyc = cyc;
                got_g2l = g2l_tok;
                got_g2s = g2s_tok;
                break;
            end
            if (tok_at > 0 && cyc == tok_at) begin
                l2g_tok = 1'b1;
                pulsed = 1;
            end else begin
                l2g_tok = 1'b0;
            end
            @(negedge clk);
        end
        l2g_tok = 1'b0;

        checkOutput("done_cycle", done_cyc, dexp);
        checkOutput("issue_count", issued, ext);
        checkOutput("issue_data_busy", bad_data, 0);
        if (ext > 0) begin
            checkOutput("first_issue", first_issue, lcyc + 1);
            checkOutput("drain_len", done_cyc - last_issue - 1, PIPE_DEPTH);
        end
        checkOutput("g2l_tok", got_g2l, w[5]);
        checkOutput("g2s_tok", got_g2s, w[6]);

        @(negedge clk);
        checkOutput("done_single", done, 1'b0);
        checkOutput("idle_ready", {busy, insn_ready}, 2'b01);

        // Token bookkeeping: pulse and consume in one instruction cancel.
        if (pulsed && w[3]) begin
        end else if (pulsed) begin
            l2g_m = satInc(l2g_m);
        end else if (w[3]) begin
            l2g_m = l2g_m - 1;
        end
        if (w[4]) s2g_m = s2g_m - 1;
        done_m++;
        busy_m += dexp;
        checkOutput("l2g_count", dut.u_l2g.count, l2g_m);
        checkOutput("s2g_count", dut.u_s2g.count, s2g_m);
    endtask

    task automatic doReset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        l2g_m = 0; s2g_m = 0; done_m = 0; busy_m = 0;
    endtask

    initial begin
        logic [127:0] w;
        int n, r, tok_at;

        // Reset state
        #1;
        checkOutput("rst_outputs", {insn_ready, busy, done, g2l_tok, g2s_tok}, 5'b0);
        checkOutput("rst_insn_out", insn_out, '0);
        checkOutput("rst_perf", {perf_cycles, perf_insns}, 64'd0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("ready_before_edge", insn_ready, 1'b0);
        @(negedge clk);
        checkOutput("ready_after_edge", insn_ready, 1'b1);

        $display("[TB] 24-cycle GEMM");
        applyStimulus(mkInsn(3'b010, 0, 0, 0, 0, 0, 4, 2, 3), 0);

        $display("[TB] GEMM stalled on l2g token");
        applyStimulus(mkInsn(3'b010, 1, 0, 1, 0, 1, 3, 1, 2), 4);

        $display("[TB] FINISH with push_next");
        applyStimulus(mkInsn(3'b011, 0, 0, 0, 1, 0, 4, 2, 3), 0);

        $display("[TB] zero-extent GEMMs");
        applyStimulus(mkInsn(3'b010, 0, 0, 1, 1, 0, 5, 2, 0), 0);
        applyStimulus(mkInsn(3'b010, 0, 0, 0, 0, 6, 2, 2, 2), 0);
        applyStimulus(mkInsn(3'b010, 0, 0, 0, 0, 3, 3, 2, 2), 0);

        $display("[TB] token saturation");
        for (int i = 0; i < 16; i++) pulseTok(1, 0);
        checkOutput("l2g_saturated", dut.u_l2g.count, 15);
        for (int i = 0; i < 14; i++) applyStimulus(mkInsn(3'b011, 1, 0, 0, 0, 0, 0, 0, 0), 0);
        checkOutput("l2g_at_one", dut.u_l2g.count, 1);
        applyStimulus(mkInsn(3'b011, 1, 0, 0, 0, 0, 0, 0, 0), 1);
        checkOutput("l2g_pulse_consume", dut.u_l2g.count, 1);

        $display("[TB] randomized instructions");
        doReset();
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            w = mkInsn((r < 7) ? 3'b010 : (r == 7) ? 3'b011 : (r == 8) ? 3'b000 : 3'b100,
                       1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 4), $urandom_range(0, 7),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) pulseTok(1'($urandom), 1'($urandom));
            if (w[4] && s2g_m == 0) pulseTok(0, 1);
            tok_at = 0;
            if (w[3] && l2g_m == 0) begin
                if ($urandom_range(0, 1) == 1) pulseTok(1, 0);
                else tok_at = $urandom_range(1, 3);
            end else if ($urandom_range(0, 3) == 0) begin
                tok_at = $urandom_range(1, 3);
            end
            applyStimulus(w, tok_at);
        end
`ifdef GEMM_CTRL_PERF_EN
        checkOutput("perf_insns", perf_insns, done_m);
        checkOutput("perf_cycles", perf_cycles, busy_m);
`else
        checkOutput("perf_off", {perf_cycles, perf_insns}, 64'd0);
`endif

        $display("[TB] reset during ISSUE");
        pulseTok(1, 0);
        pulseTok(0, 1);
        w = mkInsn(3'b010, 0, 0, 1, 1, 0, 4, 2, 3);
        for (int k = 0; k < 20 && !insn_ready; k++) @(negedge clk);
        insn_data  = w;
        insn_valid = 1'b1;
        @(negedge clk);
        insn_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && n < 10; k++) begin
            if (insn_out != '0) n++;
            if (n < 10) @(negedge clk);
        end
        checkOutput("reached_issue10", n, 10);
        rst = 1'b0;
        #1;
        checkOutput("abort_outputs", {insn_ready, busy, done, g2l_tok, g2s_tok}, 5'b0);
        checkOutput("abort_insn_out", insn_out, '0);
        checkOutput("abort_perf", {perf_cycles, perf_insns}, 64'd0);
        checkOutput("abort_tokens", {dut.u_l2g.count, dut.u_s2g.count}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_ready_pre", insn_ready, 1'b0);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || busy || g2l_tok || g2s_tok) n++;
        end
        checkOutput("abort_no_done", n, 0);
        checkOutput("abort_ready_post", insn_ready, 1'b1);
        l2g_m = 0; s2g_m = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
